// File: rtl/tm1638_frame_driver_if.sv
// Panel-side bundle for tm1638_frame_driver: frame request/status plus TM1638 pins.
// With TM1638_KEYSCAN_EN defined, the bundle also carries keys, dio_in and dio_oe.
interface tm1638_frame_driver_if #(
  parameter int unsigned NUM_DIGITS = 6
);
  logic                    update;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [7:0]              leds;
  logic [2:0]              brightness;
  logic                    display_on;
  logic                    busy;
  logic                    done;
  logic                    stb;
  logic                    sclk;
  logic                    dio;
`ifdef TM1638_KEYSCAN_EN
  logic [31:0]             keys;
  logic                    dio_in;
  logic                    dio_oe;

  modport master (
    output update, digits, dp, leds, brightness, display_on, dio_in,
    input  busy, done, stb, sclk, dio, keys, dio_oe
  );
  modport slave (
    input  update, digits, dp, leds, brightness, display_on, dio_in,
    output busy, done, stb, sclk, dio, keys, dio_oe
  );
`else
  modport master (
    output update, digits, dp, leds, brightness, display_on,
    input  busy, done, stb, sclk, dio
  );
  modport slave (
    input  update, digits, dp, leds, brightness, display_on,
    output busy, done, stb, sclk, dio
  );
`endif
endinterface

// File: rtl/tm1638_frame_driver.sv
// Snapshots digits/dp/leds/brightness on update and emits one TM1638 frame on stb/sclk/dio.
// Optional key read-back (command 0x42, 4 bytes) is enabled by defining TM1638_KEYSCAN_EN.
module tm1638_frame_driver #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned STB_GAP    = 50
) (
  input  logic                  clk_50M,
  input  logic                  RST,
  tm1638_frame_driver_if.slave  bus
);
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STB_GAP - 1);
`ifdef TM1638_KEYSCAN_EN
  localparam logic [CNT_W-1:0] KWAIT_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [1:0]       LAST_CMD   = 2'd3;
`else
  localparam logic [1:0]       LAST_CMD   = 2'd2;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STB_LOW, S_SHIFT, S_STB_HIGH, S_DONE, S_KEY_WAIT, S_READ
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [4:0]       byte_q, byte_d;
  logic [2:0]       bit_q, bit_d;
  logic             phase_q, phase_d;
  logic             stb_q, stb_d, sclk_q, sclk_d, dio_q, dio_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [31:0]      dig_q, dig_d;
  logic [7:0]       dp_q, dp_d, leds_q, leds_d;
  logic [2:0]       br_q, br_d;
  logic             on_q, on_d;
  logic [7:0]       cur_byte, nxt_byte;
  logic             half_end, last_byte;
`ifdef TM1638_KEYSCAN_EN
  logic             dio_oe_q, dio_oe_d;
  logic [31:0]      keys_q, keys_d, ksh_q, ksh_d;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Byte idx of command cmd; in C2, idx 0 is the 0xC0 address command, idx n>0 is address n-1.
  function automatic logic [7:0] byte_at(input logic [1:0] cmd, input logic [4:0] idx);
    logic [3:0] addr;
    logic [2:0] di;
    logic [7:0] b;
    addr = 4'(idx - 5'd1);
    di   = addr[3:1];
    b    = 8'h00;
    case (cmd)
      2'd0: b = 8'h40;
      2'd1: begin
        if (idx == 5'd0)                b = 8'hC0;
        else if (addr[0])               b = {7'd0, leds_q[di]};
        else if (32'(di) < NUM_DIGITS)  b = {dp_q[di], seg7(dig_q[{di, 2'b00} +: 4])};
      end
      2'd2:    b = on_q ? {5'b10001, br_q} : 8'h80;
      default: b = 8'h42;
    endcase
    return b;
  endfunction

  always_comb begin
    cur_byte  = byte_at(cmd_q, byte_q);
    nxt_byte  = byte_at(cmd_q, byte_q + 5'd1);
    half_end  = (cnt_q == HALF_LAST);
    last_byte = (cmd_q == 2'd1) ? (byte_q == 5'd16) : 1'b1;
  end

  always_ff @(posedge clk_50M or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      stb_q   <= 1'b1;
      sclk_q  <= 1'b1;
      dio_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= '0;
      dp_q    <= '0;
      leds_q  <= '0;
      br_q    <= '0;
      on_q    <= 1'b0;
`ifdef TM1638_KEYSCAN_EN
      dio_oe_q <= 1'b1;
      keys_q   <= '0;
      ksh_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      stb_q   <= stb_d;
      sclk_q  <= sclk_d;
      dio_q   <= dio_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      leds_q  <= leds_d;
      br_q    <= br_d;
      on_q    <= on_d;
`ifdef TM1638_KEYSCAN_EN
      dio_oe_q <= dio_oe_d;
      keys_q   <= keys_d;
      ksh_q    <= ksh_d;
`endif
    end
  end

  // Next state; pin outputs are computed with the transition so they register alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    cmd_d   = cmd_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    stb_d   = stb_q;
    sclk_d  = sclk_q;
    dio_d   = dio_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dig_d   = dig_q;
    dp_d    = dp_q;
    leds_d  = leds_q;
    br_d    = br_q;
    on_d    = on_q;
`ifdef TM1638_KEYSCAN_EN
    dio_oe_d = dio_oe_q;
    keys_d   = keys_q;
    ksh_d    = ksh_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d = '0;
        if (state_q == S_DONE) state_d = S_IDLE;
        if (bus.update) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          dig_d   = 32'(bus.digits);
          dp_d    = 8'(bus.dp);
          leds_d  = bus.leds;
          br_d    = bus.brightness;
          on_d    = bus.display_on;
        end
      end
      S_LOAD: begin
        state_d = S_STB_LOW;
        cnt_d   = '0;
        cmd_d   = '0;
        byte_d  = '0;
        bit_d   = '0;
        stb_d   = 1'b0;
      end
      S_STB_LOW: if (half_end) begin
        state_d = S_SHIFT;
        cnt_d   = '0;
        phase_d = 1'b0;
        sclk_d  = 1'b0;
        dio_d   = cur_byte[0];
      end
      S_SHIFT: if (half_end) begin
        cnt_d = '0;
        if (!phase_q) begin
          sclk_d  = 1'b1;
          phase_d = 1'b1;
        end else if (bit_q != 3'd7) begin
          bit_d   = bit_q + 3'd1;
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          dio_d   = cur_byte[bit_q + 3'd1];
        end else if (!last_byte) begin
          byte_d  = byte_q + 5'd1;
          bit_d   = '0;
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          dio_d   = nxt_byte[0];
`ifdef TM1638_KEYSCAN_EN
        end else if (cmd_q == 2'd3) begin
          state_d  = S_KEY_WAIT;
          dio_oe_d = 1'b0;
`endif
        end else begin
          state_d = S_STB_HIGH;
          stb_d   = 1'b1;
        end
      end
      S_STB_HIGH: if (cnt_q == GAP_LAST) begin
        cnt_d = '0;
        if (cmd_q == LAST_CMD) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef TM1638_KEYSCAN_EN
          keys_d  = ksh_q;
`endif
        end else begin
          state_d = S_STB_LOW;
          stb_d   = 1'b0;
          cmd_d   = cmd_q + 2'd1;
          byte_d  = '0;
          bit_d   = '0;
        end
      end
`ifdef TM1638_KEYSCAN_EN
      S_KEY_WAIT: if (cnt_q == KWAIT_LAST) begin
        state_d = S_READ;
        cnt_d   = '0;
        byte_d  = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        sclk_d  = 1'b0;
      end
      S_READ: if (half_end) begin
        cnt_d = '0;
        if (!phase_q) begin
          sclk_d  = 1'b1;
          phase_d = 1'b1;
          ksh_d[{byte_q[1:0], bit_q}] = bus.dio_in;
        end else if (bit_q == 3'd7 && byte_q[1:0] == 2'd3) begin
          state_d  = S_STB_HIGH;
          stb_d    = 1'b1;
          dio_oe_d = 1'b1;
        end else begin
          if (bit_q == 3'd7) byte_d = byte_q + 5'd1;
          bit_d   = bit_q + 3'd1;
          sclk_d  = 1'b0;
          phase_d = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.stb  = stb_q;
  assign bus.sclk = sclk_q;
`ifdef TM1638_KEYSCAN_EN
  assign bus.dio    = dio_oe_q ? dio_q : 1'bz;
  assign bus.dio_oe = dio_oe_q;
  assign bus.keys   = keys_q;
`else
  assign bus.dio    = dio_q;
`endif
endmodule
